// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO buffering activation/weight words between the
// host-side loader and the systolic-array feeders.
//
// Owns the storage array, the read/write pointers, the occupancy count and
// the status flags. Pointers carry one extra wrap bit so full and empty can
// be told apart when the index bits match.
//
// Build option:
//   SYNC_FIFO_FWFT_EN  defined   -> first-word fall-through: data_out shows
//                                   the head entry with zero read latency.
//                      undefined -> data_out is registered and updates one
//                                   cycle after an accepted read.
//
// Flags, count and the sticky overflow/underflow bits behave identically in
// both builds.

module sync_fifo #(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 8,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    // Reject depths the wrap-bit pointer scheme cannot represent.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("sync_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             wr_acc;
    logic             rd_acc;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // A write into a full FIFO is still taken when a read frees the slot on
    // the same edge; a read from an empty FIFO is never taken (no bypass).
    assign wr_acc = w_en & (~full | r_en);
    assign rd_acc = r_en & ~empty;

    // Next pointer values; wrapping modulo 2*DEPTH falls out of the PTR_W width.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (wr_acc) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
    end

    // Pointers and registered status flags, derived from the next pointer state
    // so the flag outputs carry no combinational path from w_en/r_en.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
            full   <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                      (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
        end
    end

    // Occupancy count: moves only when exactly one side is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full && !r_en) begin
                overflow <= 1'b1;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage write; contents are not reset, and a write coinciding with
    // reset is discarded.
    always_ff @(posedge clk) begin
        if (wr_acc && rstn) begin
            mem[wr_idx] <= data_in;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is always visible; meaningless while empty is high.
    assign data_out = mem[rd_idx];
`else
    // Registered read port: head entry captured on the accepting edge, held otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= mem[rd_idx];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (DEPTH=8, 16-bit).
// A queue holds the words expected to come out; every cycle the bench
// predicts acceptance from its own occupancy and checks flags, count,
// sticky errors and read data against that prediction.

module tb_sync_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rstn;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] last_out;
    logic          m_ovf;
    logic          m_unf;

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .w_en      (w_en),
        .r_en      (r_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"},     32'(count),     32'(mq.size()));
        check({tag, ".full"},      32'(full),      32'(mq.size() == DEPTH));
        check({tag, ".empty"},     32'(empty),     32'(mq.size() == 0));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        if (mq.size() != 0) begin
            check({tag, ".data_out"}, 32'(data_out), 32'(mq[0]));
        end
`else
        check({tag, ".data_out"}, 32'(data_out), 32'(last_out));
`endif
    endtask

    // One clock cycle of stimulus with scoreboard update and checks after the edge.
    task automatic step(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
        logic f_m;
        logic e_m;
        f_m = (mq.size() == DEPTH);
        e_m = (mq.size() == 0);
        w_en    = w;
        r_en    = r;
        data_in = d;
        if (w && f_m && !r) m_ovf = 1'b1;
        if (r && e_m)       m_unf = 1'b1;
        if (r && !e_m)      last_out = mq.pop_front();
        if (w && (!f_m || r)) mq.push_back(d);
        @(posedge clk);
        #1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
        check_status(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        last_out = '0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    initial begin
        rstn    = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_status("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_status("post_reset_idle");

        // Fill with 0x0001..0x0008; FWFT shows 0x0001 right after the first write.
        for (int i = 1; i <= DEPTH; i++) begin
            step("fill", 1'b1, 1'b0, DW'(i));
        end
        check("fill.full_final", 32'(full), 32'd1);

        // Write into a full FIFO is dropped and sets overflow.
        step("ovf", 1'b1, 1'b0, 16'hDEAD);
        check("ovf.sticky", 32'(overflow), 32'd1);

        // Simultaneous write+read at full: count stays at DEPTH.
        for (int i = 0; i < 4; i++) begin
            step("full_wr_rd", 1'b1, 1'b1, 16'h00AA);
        end

        // Drain everything: 0x0005..0x0008 then four 0x00AA.
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b0, 1'b1, '0);
        end

        // Read from empty: dropped, underflow set, data_out holds.
        step("unf", 1'b0, 1'b1, '0);
        check("unf.sticky", 32'(underflow), 32'd1);
        step("idle", 1'b0, 1'b0, '0);

        // Write+read while empty: only the write is taken.
        step("empty_wr_rd", 1'b1, 1'b1, 16'h0055);
        step("pop_55", 1'b0, 1'b1, '0);

        // Pointer wrap: hold occupancy at 3 through 20 write/read pairs.
        for (int i = 0; i < 3; i++) begin
            step("wrap_pre", 1'b1, 1'b0, DW'(16'h0100 + i));
        end
        for (int i = 3; i < 23; i++) begin
            step("wrap", 1'b1, 1'b1, DW'(16'h0100 + i));
        end
        for (int i = 0; i < 2; i++) begin
            step("to_five", 1'b1, 1'b0, DW'(16'h0200 + i));
        end
        check("to_five.count", 32'(count), 32'd5);

        // Asynchronous reset mid-cycle with a write pending.
        w_en    = 1'b1;
        data_in = 16'h0077;
        #3;
        rstn = 1'b0;
        #1;
        model_reset();
        check_status("async_reset");
        @(posedge clk);
        #1;
        check_status("reset_held_write_lost");
        w_en    = 1'b0;
        data_in = '0;
        @(negedge clk);
        rstn = 1'b1;

        // Post-reset traffic resumes from a clean state.
        step("after_rst_w", 1'b1, 1'b0, 16'h0301);
        step("after_rst_w", 1'b1, 1'b0, 16'h0302);
        step("after_rst_r", 1'b0, 1'b1, '0);
        step("after_rst_r", 1'b0, 1'b1, '0);
        check("after_rst.empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
